row_serializer: RTL and testbench

- Parallel-in, serial-out row feeder. It is the writer side of the row shift register that buffers one row of the convolution window.
- Accepts a whole row of ROW_WIDTH bytes in one valid/ready transfer and holds up to 2 rows in a ping-pong buffer.
- Streams the held rows one byte per cycle into the row shift register's serial input (shift_in / shift_in_enable), stalling while that register reports full.

---
 rtl/row_serializer_pkg.sv | 12 +
 rtl/row_slot_buf.sv | 41 ++++
 rtl/row_serializer.sv | 102 ++++++++++
 tb/tb_row_serializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/row_serializer_pkg.sv
// Shared constants and state encoding for the row serializer.
package row_serializer_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_SLOTS = 2;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } ser_state_e;

endpackage

// File: rtl/row_slot_buf.sv
// Two-slot row store: whole-row load into the write slot, byte mux out of the read slot.
module row_slot_buf
    import row_serializer_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = 8,
    parameter int unsigned IDX_W     = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        wr_slot,
    input  logic [ROW_WIDTH*BYTE_W-1:0] row_in,
    input  logic                        rd_slot,
    input  logic [IDX_W-1:0]            byte_idx,
    output logic [BYTE_W-1:0]           rd_byte
);

    logic [ROW_WIDTH*BYTE_W-1:0] mem_q [NUM_SLOTS];
    logic [ROW_WIDTH*BYTE_W-1:0] rd_row;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                mem_q[s] <= '0;
            end
        end else if (load) begin
            mem_q[wr_slot] <= row_in;
        end
    end

    always_comb begin
        rd_row  = mem_q[rd_slot];
        rd_byte = '0;
        for (int j = 0; j < ROW_WIDTH; j++) begin
            if (byte_idx == IDX_W'(j)) begin
                rd_byte = rd_row[j*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/row_serializer.sv
// Parallel-in, serial-out row feeder: ping-pongs two held rows into a row shift register
// one byte per cycle, stalling on sr_full.
module row_serializer
    import row_serializer_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = 8,
    parameter int unsigned IDX_W     = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ROW_WIDTH*BYTE_W-1:0] p_in,
    input  logic                        p_in_valid,
    output logic                        p_in_ready,
    input  logic                        sr_full,
    output logic                        shift_in_enable,
    output logic [BYTE_W-1:0]           shift_in,
    output logic                        row_done,
    output logic                        busy
);

    ser_state_e       state_q, state_d;
    logic             wr_slot_q, rd_slot_q;
    logic [1:0]       rows_held_q, rows_held_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             accept;
    logic             last_byte;
    logic [BYTE_W-1:0] rd_byte;

    row_slot_buf #(
        .ROW_WIDTH (ROW_WIDTH),
        .IDX_W     (IDX_W)
    ) u_slot_buf (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .wr_slot  (wr_slot_q),
        .row_in   (p_in),
        .rd_slot  (rd_slot_q),
        .byte_idx (byte_idx_q),
        .rd_byte  (rd_byte)
    );

    assign last_byte = (byte_idx_q == IDX_W'(ROW_WIDTH - 1));
    assign accept    = p_in_valid && p_in_ready;
    assign shift_in  = (state_q == StShift) ? rd_byte : '0;

    always_comb begin
        p_in_ready      = (rows_held_q < 2'd2);
        shift_in_enable = (state_q == StShift) && !sr_full;
        row_done        = shift_in_enable && last_byte;
        busy            = (rows_held_q != 2'd0);
        byte_idx_d      = byte_idx_q;
        rows_held_d     = rows_held_q;
        state_d         = state_q;

        if (shift_in_enable) begin
            byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
        end

        // Accept and completion on the same edge cancel out.
        unique case ({accept, row_done})
            2'b10:   rows_held_d = rows_held_q + 2'd1;
            2'b01:   rows_held_d = rows_held_q - 2'd1;
            default: rows_held_d = rows_held_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (rows_held_d != 2'd0) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (row_done && rows_held_d == 2'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            rows_held_q <= 2'd0;
            byte_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            rows_held_q <= rows_held_d;
            byte_idx_q  <= byte_idx_d;
            if (accept) begin
                wr_slot_q <= ~wr_slot_q;
            end
            if (row_done) begin
                rd_slot_q <= ~rd_slot_q;
            end
        end
    end

endmodule

// File: tb/tb_row_serializer.sv
// Scoreboarded bench for row_serializer with ROW_WIDTH=4: directed scenarios plus random traffic.
module tb_row_serializer;

    localparam int unsigned RW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [RW*8-1:0] p_in = '0;
    logic          p_in_valid = 1'b0;
    logic          p_in_ready;
    logic          sr_full = 1'b0;
    logic          shift_in_enable;
    logic [7:0]    shift_in;
    logic          row_done;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    // Expected byte stream still owed by the DUT, oldest first.
    logic [7:0] exp_q[$];

    row_serializer #(
        .ROW_WIDTH (RW),
        .IDX_W     (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .p_in            (p_in),
        .p_in_valid      (p_in_valid),
        .p_in_ready      (p_in_ready),
        .sr_full         (sr_full),
        .shift_in_enable (shift_in_enable),
        .shift_in        (shift_in),
        .row_done        (row_done),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge reset) exp_q.delete();

    // Monitor: the model says rows held = ceil(owed bytes / RW); everything follows from that.
    always @(negedge clock) begin
        int rows;
        logic exp_en;
        logic [7:0] exp_b;
        rows   = (exp_q.size() + RW - 1) / RW;
        exp_en = (rows != 0) && !sr_full;
        exp_b  = (rows != 0) ? exp_q[0] : 8'd0;
        check("p_in_ready", int'(p_in_ready), int'(rows < 2));
        check("busy", int'(busy), int'(rows != 0));
        check("shift_in_enable", int'(shift_in_enable), int'(exp_en));
        check("shift_in", int'(shift_in), int'(exp_b));
        check("row_done", int'(row_done), int'(exp_en && (exp_q.size() % RW == 1)));
        if (reset) begin
            if (shift_in_enable && exp_q.size() != 0) void'(exp_q.pop_front());
            if (p_in_valid && p_in_ready) begin
                for (int j = 0; j < RW; j++) exp_q.push_back(p_in[8*j +: 8]);
            end
        end
    end

    // Leaves p_in_valid high; returns #1 after the accepting edge.
    task automatic send_row(input logic [RW*8-1:0] d);
        bit done = 0;
        p_in = d;
        p_in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock);
            if (p_in_ready) done = 1;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: row %0h not accepted within 100 cycles", d);
        end
    endtask

    task automatic wait_owed(input int n);
        int k = 0;
        while (exp_q.size() > n && k < 200) begin
            @(posedge clock);
            k++;
        end
        #1;
        if (exp_q.size() > n) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d bytes owed, expected <= %0d", exp_q.size(), n);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", int'(p_in_ready), 1);
        check("rst_enable", int'(shift_in_enable), 0);
        check("rst_shift_in", int'(shift_in), 0);
        check("rst_row_done", int'(row_done), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;

        // Single row.
        send_row(32'h44332211);
        p_in_valid = 1'b0;
        wait_owed(0);
        repeat (3) @(posedge clock);
        #1;

        // Back-to-back rows with continuous valid.
        send_row(32'h04030201);
        send_row(32'h08070605);
        send_row(32'h0C0B0A09);
        p_in_valid = 1'b0;
        wait_owed(0);
        repeat (2) @(posedge clock);
        #1;

        // Stall while byte 02 is presented.
        send_row(32'h04030201);
        p_in_valid = 1'b0;
        @(posedge clock);
        #1;
        sr_full = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        sr_full = 1'b0;
        wait_owed(0);
        repeat (2) @(posedge clock);
        #1;

        // Reset with a partial row and a second row held.
        send_row(32'hA4A3A2A1);
        send_row(32'hB4B3B2B1);
        p_in_valid = 1'b0;
        wait_owed(6);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;

        // New row accepted on the edge that completes the only held row.
        send_row(32'hC4C3C2C1);
        p_in_valid = 1'b0;
        wait_owed(1);
        send_row(32'hD4D3D2D1);
        p_in_valid = 1'b0;
        wait_owed(0);
        repeat (2) @(posedge clock);
        #1;

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            p_in_valid = ($urandom_range(0, 2) != 0);
            p_in = $urandom;
            sr_full = ($urandom_range(0, 3) == 0);
            @(posedge clock);
            #1;
        end
        p_in_valid = 1'b0;
        sr_full = 1'b0;
        wait_owed(0);
        repeat (3) @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
